// File: rtl/instr_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO with flush and pre-sliced head fields.
// Optional macro INSTR_QUEUE_PC_EN adds a PC field stored alongside each instruction.
module instr_queue #(
  parameter  int IW    = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
`ifdef INSTR_QUEUE_PC_EN
  input  logic [IW-1:0] in_pc,
  output logic [IW-1:0] out_pc,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [4:0]    out_rs,
  output logic [4:0]    out_rt,
  output logic [15:0]   out_imm,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][IW-1:0] mem_q;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign in_ready  = !full;
  assign out_valid = !empty;

  // flush suppresses both handshakes so the counter/pointers simply clear
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset; empty masking hides stale contents
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  assign out_instr = empty ? '0 : mem_q[rd_ptr_q];
  assign out_rs    = out_instr[25:21];
  assign out_rt    = out_instr[20:16];
  assign out_imm   = out_instr[15:0];

`ifdef INSTR_QUEUE_PC_EN
  logic [DEPTH-1:0][IW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (push) pc_q[wr_ptr_q] <= in_pc;
  end

  assign out_pc = empty ? '0 : pc_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: stimulus queues expected pops, a negedge monitor checks each pop.
module tb_instr_queue;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [IW-1:0] in_instr, in_pc;
  logic          in_ready, out_valid, full, empty;
  logic [IW-1:0] out_instr;
  logic [4:0]    out_rs, out_rt;
  logic [15:0]   out_imm;
  logic [CW-1:0] count;
`ifdef INSTR_QUEUE_PC_EN
  logic [IW-1:0] out_pc;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  instr_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
`ifdef INSTR_QUEUE_PC_EN
    .in_pc(in_pc), .out_pc(out_pc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: a pop will happen on the coming posedge
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected act=%h exp=none", out_instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_instr", out_instr, e);
        chk("pop_rs", {27'd0, out_rs}, {27'd0, e[25:21]});
        chk("pop_rt", {27'd0, out_rt}, {27'd0, e[20:16]});
        chk("pop_imm", {16'd0, out_imm}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic push1(input logic [31:0] v);
    in_valid = 1'b1; in_instr = v; exp_q.push_back(v);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);

    // single push, field slicing
    push1(32'h8C220004);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_instr", out_instr, 32'h8C220004);
    chk("p1_rs", 32'(out_rs), 32'd1);
    chk("p1_rt", 32'(out_rt), 32'd2);
    chk("p1_imm", 32'(out_imm), 32'h0004);
    chk("p1_count", 32'(count), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("p1_empty", 32'(empty), 32'd1);

    // overfill: 0x55 must be refused
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = 32'h11 * (i + 1);
      if (i < 4) exp_q.push_back(32'h11 * (i + 1));
      if (i == 4) begin
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
      end
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // steady push+pop across pointer wrap
    push1(32'hA1); push1(32'hA2); push1(32'hA3);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = 32'hB1 + i; exp_q.push_back(32'hB1 + i);
      step();
      chk("pp_count", 32'(count), 32'd3);
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    chk("pp_empty", 32'(empty), 32'd1);

    // push+pop with a single entry: head moves to the new word
    push1(32'hF1);
    in_valid = 1'b1; in_instr = 32'hF2; exp_q.push_back(32'hF2); out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_head", out_instr, 32'hF2);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // flush wins over push and pop
    push1(32'hC1); push1(32'hC2);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDD; out_ready = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_instr", out_instr, 32'd0);
    push1(32'hAA);
    chk("fl_push_head", out_instr, 32'hAA);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // reset during activity
    push1(32'hE1); push1(32'hE2); push1(32'hE3);
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'hE4; out_ready = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rs2_count", 32'(count), 32'd0);
    chk("rs2_empty", 32'(empty), 32'd1);
    chk("rs2_full", 32'(full), 32'd0);
    chk("rs2_valid", 32'(out_valid), 32'd0);
`ifdef INSTR_QUEUE_PC_EN
    chk("rs2_pc", out_pc, 32'd0);
`endif
    in_pc = 32'h400;
    push1(32'h77);
    in_pc = '0;
    chk("rs2_head", out_instr, 32'h77);
`ifdef INSTR_QUEUE_PC_EN
    chk("pc_head", out_pc, 32'h400);
`endif
    out_ready = 1'b1; step(); out_ready = 1'b0;
    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
